grf_wr_arbiter: RTL and testbench

Owns the single GRF write port and shares it between the W-stage writeback (fixed priority, never back-pressured) and a secondary multi-cycle result source (MDU/late writeback, valid/ready). Secondary writes are buffered in a small FIFO and drained into cycles where W does not write. Also reports pending-write hits on the D-stage read addresses so the hazard unit can stall.

---
 rtl/grf_arb_pkg.sv | 15 +
 rtl/grf_wr_arbiter_if.sv | 32 +++
 rtl/grf_arb_fifo.sv | 71 +++++++
 rtl/grf_wr_arbiter.sv | 103 ++++++++++
 tb/tb_grf_wr_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/grf_arb_pkg.sv
// Shared types and constants for the GRF write-port arbiter.
package grf_arb_pkg;

  localparam logic [4:0]  REG_ZERO             = 5'd0;
  localparam int unsigned DEPTH_DEFAULT        = 2;
  localparam int unsigned STARVE_LIMIT_DEFAULT = 8;

  // One buffered secondary write; live=0 means a newer W write superseded it.
  typedef struct packed {
    logic        live;
    logic [4:0]  a3;
    logic [31:0] wd;
  } entry_t;

endpackage

// File: rtl/grf_wr_arbiter_if.sv
// Bundle of W-stage, secondary, D-stage hazard and GRF write-port signals.
interface grf_wr_arbiter_if;

  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd;
  logic        s_valid;
  logic [4:0]  s_a3;
  logic [31:0] s_wd;
  logic        s_ready;
  logic [4:0]  rd_a1;
  logic [4:0]  rd_a2;
  logic        pend_hit1;
  logic        pend_hit2;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic        w_stall_req;

  // Pipeline side: drives requests, observes the arbiter's decisions.
  modport master (
    output w_we, w_a3, w_wd, s_valid, s_a3, s_wd, rd_a1, rd_a2,
    input  s_ready, pend_hit1, pend_hit2, grf_we, grf_a3, grf_wd, w_stall_req
  );

  // Arbiter side.
  modport slave (
    input  w_we, w_a3, w_wd, s_valid, s_a3, s_wd, rd_a1, rd_a2,
    output s_ready, pend_hit1, pend_hit2, grf_we, grf_a3, grf_wd, w_stall_req
  );

endinterface

// File: rtl/grf_arb_fifo.sv
// Secondary-write FIFO with per-entry kill-by-address and live-entry address match.
module grf_arb_fifo
  import grf_arb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_push,
  input  entry_t     i_push_entry,
  input  logic       i_pop,
  input  logic       i_kill_en,
  input  logic [4:0] i_kill_a3,
  input  logic [4:0] i_match_a1,
  input  logic [4:0] i_match_a2,
  output entry_t     o_head,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_hit1,
  output logic       o_hit2
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  entry_t            r_mem [DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;

  // Entry storage, pointers and occupancy; popped slots drop live so only
  // occupied, unsuperseded entries can ever match.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_kill_en && r_mem[i].live && (r_mem[i].a3 == i_kill_a3)) r_mem[i].live <= 1'b0;
      end
      if (i_pop) begin
        r_mem[r_rd_ptr].live <= 1'b0;
        r_rd_ptr             <= r_rd_ptr + PtrW'(1);
      end
      // Push lands last so a same-cycle push of the killed address stays live.
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (i_push && !i_pop)      r_count <= r_count + CntW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CntW'(1);
    end
  end

  // Address match against live entries only.
  always_comb begin
    o_hit1 = 1'b0;
    o_hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].live && (i_match_a1 != REG_ZERO) && (r_mem[i].a3 == i_match_a1)) o_hit1 = 1'b1;
      if (r_mem[i].live && (i_match_a2 != REG_ZERO) && (r_mem[i].a3 == i_match_a2)) o_hit2 = 1'b1;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntW'(DEPTH));

endmodule

// File: rtl/grf_wr_arbiter.sv
// GRF write-port arbiter: W stage has fixed priority, secondary writes are
// buffered and drained into W-idle cycles. Optional starvation guard is
// enabled by defining GRF_ARB_STARVE_GUARD_EN.
module grf_wr_arbiter
  import grf_arb_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input logic             clk,
  input logic             reset,
  grf_wr_arbiter_if.slave bus
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (STARVE_LIMIT < 1)) begin : g_bad_params
    $error("grf_wr_arbiter: DEPTH must be a power of two >= 2, STARVE_LIMIT >= 1");
  end

  entry_t w_head;
  entry_t w_push_entry;
  logic   w_empty;
  logic   w_full;
  logic   w_fifo_hit1;
  logic   w_fifo_hit2;
  logic   w_w_own;
  logic   w_pop;
  logic   w_push;
  logic   w_s_ready;

  assign w_w_own      = !reset && bus.w_we && (bus.w_a3 != REG_ZERO);
  assign w_pop        = !reset && !w_w_own && !w_empty;
  assign w_s_ready    = !reset && !w_full;
  // Writes to $0 are acknowledged but never buffered.
  assign w_push       = bus.s_valid && w_s_ready && (bus.s_a3 != REG_ZERO);
  assign w_push_entry = '{live: 1'b1, a3: bus.s_a3, wd: bus.s_wd};

  grf_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_kill_en    (w_w_own),
    .i_kill_a3    (bus.w_a3),
    .i_match_a1   (bus.rd_a1),
    .i_match_a2   (bus.rd_a2),
    .o_head       (w_head),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_hit1       (w_fifo_hit1),
    .o_hit2       (w_fifo_hit2)
  );

  // Write-port select: W first, else drain FIFO head (killed head pops silently).
  always_comb begin
    bus.grf_we = 1'b0;
    bus.grf_a3 = REG_ZERO;
    bus.grf_wd = '0;
    if (w_w_own) begin
      bus.grf_we = 1'b1;
      bus.grf_a3 = bus.w_a3;
      bus.grf_wd = bus.w_wd;
    end else if (w_pop) begin
      bus.grf_we = w_head.live;
      bus.grf_a3 = w_head.a3;
      bus.grf_wd = w_head.wd;
    end
  end

  // Pending-write hazard: live buffered entries plus this cycle's accepted push.
  always_comb begin
    bus.pend_hit1 = 1'b0;
    bus.pend_hit2 = 1'b0;
    if (!reset) begin
      bus.pend_hit1 = w_fifo_hit1 || (w_push && (bus.rd_a1 == bus.s_a3));
      bus.pend_hit2 = w_fifo_hit2 || (w_push && (bus.rd_a2 == bus.s_a3));
    end
  end

  assign bus.s_ready = w_s_ready;

`ifdef GRF_ARB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  logic [StarveW-1:0] r_starve_cnt;

  // Count cycles the FIFO waits without a pop; saturates at the limit.
  always_ff @(posedge clk) begin
    if (reset || w_pop || w_empty) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt < StarveW'(STARVE_LIMIT)) begin
      r_starve_cnt <= r_starve_cnt + StarveW'(1);
    end
  end

  assign bus.w_stall_req = !reset && (r_starve_cnt >= StarveW'(STARVE_LIMIT));
`else
  assign bus.w_stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Directed self-checking bench for grf_wr_arbiter (DEPTH=2, STARVE_LIMIT=8).
module tb_grf_wr_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic exp_stall;

  grf_wr_arbiter_if bus ();

  grf_wr_arbiter #(
    .DEPTH        (2),
    .STARVE_LIMIT (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_idle();
    bus.w_we    = 1'b0;
    bus.w_a3    = 5'd0;
    bus.w_wd    = 32'h0;
    bus.s_valid = 1'b0;
    bus.s_a3    = 5'd0;
    bus.s_wd    = 32'h0;
    bus.rd_a1   = 5'd0;
    bus.rd_a2   = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic w_write(input logic [4:0] a3, input logic [31:0] wd);
    bus.w_we = 1'b1;
    bus.w_a3 = a3;
    bus.w_wd = wd;
  endtask

  task automatic s_push(input logic [4:0] a3, input logic [31:0] wd);
    bus.s_valid = 1'b1;
    bus.s_a3    = a3;
    bus.s_wd    = wd;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    w_write(5'd8, 32'hDEAD);
    s_push(5'd5, 32'h1);
    bus.rd_a1 = 5'd5;
    tick();
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL rst_grf_we: got %b want 0", bus.grf_we); end
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL rst_s_ready: got %b want 0", bus.s_ready); end
    n_cmp++; if (bus.pend_hit1 !== 1'b0) begin n_err++; $display("FAIL rst_pend_hit1: got %b want 0", bus.pend_hit1); end
    n_cmp++; if (bus.w_stall_req !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", bus.w_stall_req); end
    tick();
    set_idle();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_idle();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL idle_grf_we: got %b want 0", bus.grf_we); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL idle_s_ready: got %b want 1", bus.s_ready); end
    tick();
    s_push(5'd5, 32'h1234);
    bus.rd_a1 = 5'd5;
    #1;
    n_cmp++; if (bus.pend_hit1 !== 1'b1) begin n_err++; $display("FAIL push_pend_hit1: got %b want 1", bus.pend_hit1); end
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL push_no_bypass: got %b want 0", bus.grf_we); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b1) begin n_err++; $display("FAIL drain_we: got %b want 1", bus.grf_we); end
    n_cmp++; if (bus.grf_a3 !== 5'd5) begin n_err++; $display("FAIL drain_a3: got %0d want 5", bus.grf_a3); end
    n_cmp++; if (bus.grf_wd !== 32'h1234) begin n_err++; $display("FAIL drain_wd: got %h want 00001234", bus.grf_wd); end
    tick();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL drain_done_we: got %b want 0", bus.grf_we); end
    tick();
  endtask

  task automatic test_fill();
    set_idle();
    w_write(5'd8, 32'hAAAA);
    s_push(5'd3, 32'h33);
    #1;
    n_cmp++; if (bus.grf_a3 !== 5'd8) begin n_err++; $display("FAIL fill_w_a3: got %0d want 8", bus.grf_a3); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready0: got %b want 1", bus.s_ready); end
    tick();
    s_push(5'd4, 32'h44);
    #1;
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready1: got %b want 1", bus.s_ready); end
    tick();
    s_push(5'd7, 32'h77);
    #1;
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready: got %b want 0", bus.s_ready); end
    tick();
    #1;
    n_cmp++; if (bus.grf_wd !== 32'hAAAA) begin n_err++; $display("FAIL fill_w_wd: got %h want 0000aaaa", bus.grf_wd); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (bus.grf_a3 !== 5'd3 || bus.grf_we !== 1'b1) begin n_err++; $display("FAIL fill_pop3: got we=%b a3=%0d want we=1 a3=3", bus.grf_we, bus.grf_a3); end
    n_cmp++; if (bus.s_ready !== 1'b0) begin n_err++; $display("FAIL fill_no_pop_bypass: got %b want 0", bus.s_ready); end
    tick();
    #1;
    n_cmp++; if (bus.grf_a3 !== 5'd4 || bus.grf_wd !== 32'h44) begin n_err++; $display("FAIL fill_pop4: got a3=%0d wd=%h want a3=4 wd=00000044", bus.grf_a3, bus.grf_wd); end
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_after: got %b want 1", bus.s_ready); end
    tick();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL fill_rejected_not_queued: got %b want 0", bus.grf_we); end
    tick();
  endtask

  task automatic test_kill();
    // Kill with a same-cycle newer push of the same register.
    set_idle();
    s_push(5'd9, 32'h1);
    tick();
    set_idle();
    w_write(5'd9, 32'h2);
    s_push(5'd9, 32'h3);
    #1;
    n_cmp++; if (bus.grf_a3 !== 5'd9 || bus.grf_wd !== 32'h2) begin n_err++; $display("FAIL kill_w_wins: got a3=%0d wd=%h want a3=9 wd=00000002", bus.grf_a3, bus.grf_wd); end
    tick();
    set_idle();
    bus.rd_a1 = 5'd9;
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL kill_pop_silent: got %b want 0", bus.grf_we); end
    n_cmp++; if (bus.pend_hit1 !== 1'b1) begin n_err++; $display("FAIL kill_newer_live_hit: got %b want 1", bus.pend_hit1); end
    tick();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b1 || bus.grf_wd !== 32'h3) begin n_err++; $display("FAIL kill_newer_write: got we=%b wd=%h want we=1 wd=00000003", bus.grf_we, bus.grf_wd); end
    tick();
    // Plain kill: entry superseded, no hit and no write on drain.
    set_idle();
    s_push(5'd9, 32'h1);
    tick();
    set_idle();
    w_write(5'd9, 32'h2);
    tick();
    set_idle();
    bus.rd_a2 = 5'd9;
    #1;
    n_cmp++; if (bus.pend_hit2 !== 1'b0) begin n_err++; $display("FAIL kill_no_hit: got %b want 0", bus.pend_hit2); end
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL kill_drain_silent: got %b want 0", bus.grf_we); end
    tick();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0 || bus.s_ready !== 1'b1) begin n_err++; $display("FAIL kill_empty: got we=%b ready=%b want we=0 ready=1", bus.grf_we, bus.s_ready); end
    tick();
  endtask

  task automatic test_zero_push();
    set_idle();
    w_write(5'd8, 32'hB);
    s_push(5'd0, 32'h55);
    #1;
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL zero_accepted: got %b want 1", bus.s_ready); end
    n_cmp++; if (bus.pend_hit1 !== 1'b0) begin n_err++; $display("FAIL zero_no_hit: got %b want 0", bus.pend_hit1); end
    tick();
    s_push(5'd12, 32'hC);
    #1;
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL zero_count_a: got %b want 1", bus.s_ready); end
    tick();
    s_push(5'd13, 32'hD);
    #1;
    n_cmp++; if (bus.s_ready !== 1'b1) begin n_err++; $display("FAIL zero_count_b: got %b want 1", bus.s_ready); end
    tick();
    set_idle();
    #1;
    n_cmp++; if (bus.grf_a3 !== 5'd12) begin n_err++; $display("FAIL zero_drain12: got %0d want 12", bus.grf_a3); end
    tick();
    #1;
    n_cmp++; if (bus.grf_a3 !== 5'd13) begin n_err++; $display("FAIL zero_drain13: got %0d want 13", bus.grf_a3); end
    tick();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL zero_never_written: got %b want 0", bus.grf_we); end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    set_idle();
    w_write(5'd8, 32'hE);
    s_push(5'd10, 32'hA0);
    tick();
    s_push(5'd11, 32'hB0);
    tick();
    set_idle();
    #1;
    n_cmp++; if (bus.grf_a3 !== 5'd10) begin n_err++; $display("FAIL rmid_pop10: got %0d want 10", bus.grf_a3); end
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0 || bus.s_ready !== 1'b0) begin n_err++; $display("FAIL rmid_in_reset: got we=%b ready=%b want 0 0", bus.grf_we, bus.s_ready); end
    tick();
    reset = 1'b0;
    bus.rd_a1 = 5'd11;
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0 || bus.s_ready !== 1'b1) begin n_err++; $display("FAIL rmid_after: got we=%b ready=%b want 0 1", bus.grf_we, bus.s_ready); end
    n_cmp++; if (bus.pend_hit1 !== 1'b0) begin n_err++; $display("FAIL rmid_no_stale_hit: got %b want 0", bus.pend_hit1); end
    tick();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b0) begin n_err++; $display("FAIL rmid_no_stale_write: got %b want 0", bus.grf_we); end
    tick();
  endtask

  task automatic test_starve();
    set_idle();
    w_write(5'd8, 32'hF);
    s_push(5'd14, 32'h14);
    tick();
    bus.s_valid = 1'b0;
    for (int p = 1; p <= 9; p++) begin
      #1;
      if (p == 8) begin
        n_cmp++; if (bus.w_stall_req !== 1'b0) begin n_err++; $display("FAIL starve_below_limit: got %b want 0", bus.w_stall_req); end
      end
      if (p == 9) begin
        n_cmp++; if (bus.w_stall_req !== exp_stall) begin n_err++; $display("FAIL starve_at_limit: got %b want %b", bus.w_stall_req, exp_stall); end
      end
      tick();
    end
    set_idle();
    #1;
    n_cmp++; if (bus.grf_we !== 1'b1 || bus.grf_a3 !== 5'd14) begin n_err++; $display("FAIL starve_pop: got we=%b a3=%0d want we=1 a3=14", bus.grf_we, bus.grf_a3); end
    tick();
    #1;
    n_cmp++; if (bus.w_stall_req !== 1'b0) begin n_err++; $display("FAIL starve_cleared: got %b want 0", bus.w_stall_req); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
`ifdef GRF_ARB_STARVE_GUARD_EN
    exp_stall = 1'b1;
`else
    exp_stall = 1'b0;
`endif
    reset = 1'b1;
    set_idle();
    test_reset();
    test_basic();
    test_fill();
    test_kill();
    test_zero_push();
    test_reset_mid_drain();
    test_starve();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
